// File: rtl/prbs_block_scrambler_pkg.sv
// Shared constants and types for the block scrambler: default 1 + x^14 + x^15
// polynomial, its standard seed, and the block-tracking FSM state.
package prbs_block_scrambler_pkg;

  localparam logic [14:0] TAPS_802_16 = 15'h6000;
  localparam logic [14:0] SEED_802_16 = 15'h00A9;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_W-step LFSR advance: scrambles one beat MSB-first and
// returns the state after the last step (held unchanged when bypassed).
module prbs_lfsr_step
  import prbs_block_scrambler_pkg::*;
#(
  parameter int                LFSR_W = 15,
  parameter logic [LFSR_W-1:0] TAPS   = TAPS_802_16,
  parameter int                DATA_W = 8
) (
  input  logic [LFSR_W-1:0] state,
  input  logic [DATA_W-1:0] data,
  input  logic              bypass,
  output logic [LFSR_W-1:0] next_state,
  output logic [DATA_W-1:0] scrambled
);

  logic [LFSR_W-1:0] chain [DATA_W+1];
  logic [DATA_W-1:0] keystream;

  assign chain[0] = state;

  // Step gi consumes data bit DATA_W-1-gi, so the MSB sees the first feedback bit.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
    logic fb;
    assign fb                    = ^(chain[gi] & TAPS);
    assign chain[gi+1]           = {chain[gi][LFSR_W-2:0], fb};
    assign keystream[DATA_W-1-gi] = fb;
  end

  assign next_state = bypass ? state : chain[DATA_W];
  assign scrambled  = bypass ? data  : (data ^ keystream);

endmodule

// File: rtl/prbs_block_scrambler.sv
// Block-reseeded bit-parallel PRBS scrambler with a single registered output
// stage; the same instance descrambles because the keystream is data independent.
module prbs_block_scrambler
  import prbs_block_scrambler_pkg::*;
#(
  parameter int                LFSR_W   = 15,
  parameter logic [LFSR_W-1:0] TAPS     = TAPS_802_16,
  parameter int                DATA_W   = 8,
  parameter logic [LFSR_W-1:0] SEED_RST = SEED_802_16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              cfg_bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic [LFSR_W-1:0] lfsr_state,
  output logic              frame_err,
  output logic              seed_zero_err
);

  fsm_state_t        state_reg, state_next;
  logic [LFSR_W-1:0] lfsr_reg, seed_reg;
  logic [LFSR_W-1:0] seed_sel, step_state, step_next;
  logic [DATA_W-1:0] step_data;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg, out_first_reg, out_last_reg;
  logic              frame_err_reg, seed_zero_err_reg;
  logic              accept, reseed, frame_viol;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // A load coinciding with a reseeding beat is forwarded straight into the step.
  assign seed_sel   = cfg_load ? cfg_seed : seed_reg;
  assign step_state = reseed ? seed_sel : lfsr_reg;

  prbs_lfsr_step #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_step (
    .state      (step_state),
    .data       (in_data),
    .bypass     (cfg_bypass),
    .next_state (step_next),
    .scrambled  (step_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = in_last ? IDLE : ACTIVE;
    end
  end

  // Any beat arriving in IDLE starts a block, well-formed or not.
  always_comb begin
    reseed     = 1'b0;
    frame_viol = 1'b0;
    case (state_reg)
      IDLE: begin
        reseed     = 1'b1;
        frame_viol = !in_first;
      end
      ACTIVE: begin
        reseed     = in_first;
        frame_viol = in_first;
      end
      default: begin
        reseed     = 1'b0;
        frame_viol = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg          <= '0;
      seed_reg          <= SEED_RST;
      out_valid_reg     <= 1'b0;
      out_first_reg     <= 1'b0;
      out_last_reg      <= 1'b0;
      out_data_reg      <= '0;
      frame_err_reg     <= 1'b0;
      seed_zero_err_reg <= 1'b0;
    end else begin
      if (cfg_load) begin
        seed_reg <= cfg_seed;
        if (cfg_seed == '0) begin
          seed_zero_err_reg <= 1'b1;
        end
      end
      if (accept) begin
        lfsr_reg      <= step_next;
        out_data_reg  <= step_data;
        out_first_reg <= in_first;
        out_last_reg  <= in_last;
        out_valid_reg <= 1'b1;
        if (frame_viol) begin
          frame_err_reg <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_data      = out_data_reg;
  assign out_first     = out_first_reg;
  assign out_last      = out_last_reg;
  assign lfsr_state    = lfsr_reg;
  assign frame_err     = frame_err_reg;
  assign seed_zero_err = seed_zero_err_reg;

endmodule

// File: tb/tb_prbs_block_scrambler.sv
// Randomised and directed bench for prbs_block_scrambler, checked every cycle
// against a keystream-recurrence model plus hand-derived literal vectors.
module tb_prbs_block_scrambler;

  localparam int          DATA_W = 8;
  localparam logic [14:0] TAPS   = 15'h6000;
  localparam logic [14:0] SEED   = 15'h00A9;

  logic        clk, rst;
  logic        cfg_load, cfg_bypass;
  logic [14:0] cfg_seed;
  logic        in_valid, in_ready, in_first, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_first, out_last;
  logic [7:0]  out_data;
  logic [14:0] lfsr_state;
  logic        frame_err, seed_zero_err;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;
  logic [7:0] got [$];
  logic [7:0] ref_seq [$];

  prbs_block_scrambler dut (
    .clk           (clk),
    .reset         (rst),
    .cfg_load      (cfg_load),
    .cfg_seed      (cfg_seed),
    .cfg_bypass    (cfg_bypass),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_first      (in_first),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_first     (out_first),
    .out_last      (out_last),
    .lfsr_state    (lfsr_state),
    .frame_err     (frame_err),
    .seed_zero_err (seed_zero_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keystream k[n] = XOR of k[n-j-1] over tap bits j; m_hist[j] holds k[n-j-1],
  // i.e. stage j+1 of the register.
  logic       m_out_valid, m_out_first, m_out_last, m_active, m_frame_err, m_zero_err;
  logic [7:0] m_out_data;
  logic [14:0] m_seed;
  bit         m_hist [$];
  bit         kb;

  task automatic m_load_hist(input logic [14:0] s);
    m_hist.delete();
    for (int k = 0; k < 15; k++) m_hist.push_back(s[k]);
  endtask

  task automatic m_next_bit(output bit nb);
    nb = 1'b0;
    for (int j = 0; j < 15; j++) if (TAPS[j]) nb = nb ^ m_hist[j];
    m_hist.push_front(nb);
    void'(m_hist.pop_back());
  endtask

  function automatic logic [14:0] m_lfsr();
    logic [14:0] v;
    v = '0;
    for (int k = 0; k < 15; k++) if (k < m_hist.size()) v[k] = m_hist[k];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out_valid = 1'b0; m_out_first = 1'b0; m_out_last = 1'b0; m_out_data = 8'h00;
      m_active = 1'b0; m_frame_err = 1'b0; m_zero_err = 1'b0; m_seed = SEED;
      m_load_hist(15'h0);
    end else begin
      if (in_valid && (!m_out_valid || out_ready)) begin
        if ((!m_active && !in_first) || (m_active && in_first)) m_frame_err = 1'b1;
        if (!m_active || in_first) m_load_hist(cfg_load ? cfg_seed : m_seed);
        for (int b = DATA_W - 1; b >= 0; b--) begin
          if (cfg_bypass) m_out_data[b] = in_data[b];
          else begin
            m_next_bit(kb);
            m_out_data[b] = in_data[b] ^ kb;
          end
        end
        m_out_first = in_first;
        m_out_last  = in_last;
        m_out_valid = 1'b1;
        m_active    = !in_last;
      end else if (out_ready) begin
        m_out_valid = 1'b0;
      end
      if (cfg_load) begin
        if (cfg_seed == 15'h0) m_zero_err = 1'b1;
        m_seed = cfg_seed;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_out_valid));
    if (m_out_valid) begin
      chk("out_data", 32'(out_data), 32'(m_out_data));
      chk("out_first", 32'(out_first), 32'(m_out_first));
      chk("out_last", 32'(out_last), 32'(m_out_last));
    end
    chk("in_ready", 32'(in_ready), 32'(!m_out_valid || out_ready));
    chk("frame_err", 32'(frame_err), 32'(m_frame_err));
    chk("seed_zero_err", 32'(seed_zero_err), 32'(m_zero_err));
    chk("lfsr_state", 32'(lfsr_state), 32'(m_lfsr()));
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic f, input logic l,
                      input logic byp, input logic ld, input logic [14:0] sd);
    bit ok;
    int n;
    in_data = d; in_first = f; in_last = l; cfg_bypass = byp;
    cfg_load = ld; cfg_seed = sd; in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        ok = 1'b1;
      end
    end
    in_valid = 1'b0; cfg_load = 1'b0; in_first = 1'b0; in_last = 1'b0; cfg_bypass = 1'b0;
  endtask

  task automatic load_seed(input logic [14:0] sd);
    cfg_load = 1'b1; cfg_seed = sd;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++;
    if (got.size() < n) begin
      errors++;
      $display("FAIL drain: got %0d beats expected %0d", got.size(), n);
    end
  endtask

  task automatic check_got(input string name, input logic [7:0] exp [$]);
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s%0d", name, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_first", 32'(out_first), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_lfsr", 32'(lfsr_state), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_seed_zero_err", 32'(seed_zero_err), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] e [$];
    logic [7:0] blk [$];
    rst = 1'b0; cfg_load = 1'b0; cfg_seed = '0; cfg_bypass = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Keystream from seed 00A9 under the stepping rule: 03 F6 08 34.
    send(8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'hC4, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'h79, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
    wait_got(4);
    e = '{8'h46, 8'hDF, 8'hCC, 8'h4D};
    check_got("std", e);
    $display("standard block out %h %h %h %h", got[0], got[1], got[2], got[3]);

    // Descramble with the same instance.
    blk = got;
    got.delete();
    for (int i = 0; i < 4; i++) send(blk[i], 1'(i == 0), 1'(i == 3), 1'b0, 1'b0, 15'h0);
    wait_got(4);
    e = '{8'h45, 8'h29, 8'hC4, 8'h79};
    check_got("inverse", e);

    // Single-beat block, then a proper two-beat block: no framing error.
    got.delete();
    send(8'h45, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0);
    send(8'h29, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'hC4, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
    wait_got(3);
    e = '{8'h46, 8'h2A, 8'h32};
    check_got("single", e);
    chk("single_frame_err", 32'(frame_err), 32'h0);

    // Backpressure: same block unstalled then stalled must give the same bytes.
    blk.delete();
    for (int i = 0; i < 6; i++) blk.push_back(8'($urandom_range(0, 255)));
    got.delete();
    for (int i = 0; i < 6; i++) send(blk[i], 1'(i == 0), 1'(i == 5), 1'b0, 1'b0, 15'h0);
    wait_got(6);
    ref_seq = got;
    got.delete();
    for (int i = 0; i < 3; i++) send(blk[i], 1'(i == 0), 1'b0, 1'b0, 1'b0, 15'h0);
    out_ready = 1'b0;
    fork
      send(blk[3], 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(blk[4], 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
    send(blk[5], 1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
    wait_got(6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("stall_seq%0d", i), 32'(got[i]), 32'(ref_seq[i]));

    // Mid-block load, next block from 7FFF, then a coincident load forwarded.
    got.delete();
    send(8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 15'h7FFF);
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
    send(8'h45, 1'b1, 1'b1, 1'b0, 1'b1, SEED);
    wait_got(5);
    e = '{8'h46, 8'hDF, 8'hA5, 8'h02, 8'h46};
    check_got("reseed", e);

    // Framing errors reseed and stick.
    got.delete();
    chk("frame_err_before", 32'(frame_err), 32'h0);
    send(8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
    chk("frame_err_idle", 32'(frame_err), 32'h1);
    send(8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
    wait_got(4);
    e = '{8'h46, 8'hDF, 8'h46, 8'hDF};
    check_got("frame", e);
    chk("frame_err_sticky", 32'(frame_err), 32'h1);

    // Bypass: first beat loads the seed unstepped, later bypass freezes state.
    got.delete();
    send(8'h45, 1'b1, 1'b0, 1'b1, 1'b0, 15'h0);
    chk("bypass_seed_lfsr", 32'(lfsr_state), 32'(SEED));
    send(8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
    chk("bypass_step_lfsr", 32'(lfsr_state), 32'h2903);
    send(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0);
    chk("bypass_frozen_lfsr", 32'(lfsr_state), 32'h2903);
    wait_got(3);
    e = '{8'h45, 8'h2A, 8'h77};
    check_got("bypass", e);

    // Zero seed: flagged, and the next block passes through.
    load_seed(15'h0);
    chk("zero_seed_err", 32'(seed_zero_err), 32'h1);
    got.delete();
    send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    send(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0);
    wait_got(2);
    e = '{8'h5A, 8'hC3};
    check_got("zero", e);
    chk("zero_lfsr", 32'(lfsr_state), 32'h0);

    // Reset mid-block with a beat held in the output register.
    out_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0);
    #2 rst = 1'b1;
    #1 check_reset_state();
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    send(8'h45, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0);
    wait_got(1);
    e = '{8'h46};
    check_got("post_reset", e);

    // Randomised blocks with random backpressure, loads and bypass.
    rand_ready = 1'b1;
    for (int blkn = 0; blkn < 80; blkn++) begin
      int len;
      logic f, l;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        f = (b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
        l = (b == len - 1) ? ($urandom_range(0, 9) != 0) : 1'b0;
        send(8'($urandom_range(0, 255)), f, l, 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 7) == 0),
             ($urandom_range(0, 15) == 0) ? 15'h0 : 15'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
